// File: rtl/viu_pkg.sv
// Shared VIU types: route control word layout and TX arbiter states.
// Also used by vlan_tagger and gateway_tx.
package viu_pkg;

   localparam int ROUTE_W      = 14;
   localparam int AXI_NET_BITS = 512;

   typedef struct packed {
      logic [1:0] src_node;
      logic [3:0] src_vfpga;
      logic [1:0] dst_node;
      logic [3:0] dst_vfpga;
      logic [1:0] rsvd;
   } route_t;

   typedef enum logic {
      ST_IDLE,
      ST_STREAM
   } arb_state_t;

   // Index width for n requesters, never narrower than one bit.
   function automatic int idx_w(int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/viu_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set req strictly after rr_ptr,
// scanning upward with wrap. Shared between the TX and RX paths.
module rr_arbiter
   import viu_pkg::*;
#(
   parameter int  NUM_VFPGA = 4,
   localparam int PW        = idx_w(NUM_VFPGA)
) (
   input  logic [NUM_VFPGA-1:0] req,
   input  logic [PW-1:0]        rr_ptr,
   output logic [PW-1:0]        winner,
   output logic                 valid
);

   logic [PW-1:0] idx;

   // Explicit compare keeps the wrap correct for non power-of-two counts.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = rr_ptr;
      for (int k = 0; k < NUM_VFPGA; k++) begin
         idx = (idx == PW'(NUM_VFPGA - 1)) ? '0 : idx + PW'(1);
         if (!valid && req[idx]) begin
            winner = idx;
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/viu_tx_arbiter.sv
// Per-packet round-robin arbiter feeding the VLAN tagger from NUM_VFPGA
// vFPGA TX streams; route word is held for the whole granted frame.
module viu_tx_arbiter
   import viu_pkg::*;
#(
   parameter int  NUM_VFPGA  = 4,
   parameter int  DATA_WIDTH = AXI_NET_BITS,
   localparam int PW         = idx_w(NUM_VFPGA),
   localparam int KW         = DATA_WIDTH / 8
) (
   input  logic                            aclk,
   input  logic                            aresetn,
   input  logic [NUM_VFPGA-1:0]            ctrl_en_mask,
   input  logic [NUM_VFPGA*ROUTE_W-1:0]    s_route,
   input  logic [NUM_VFPGA*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_VFPGA*KW-1:0]         s_axis_tkeep,
   input  logic [NUM_VFPGA-1:0]            s_axis_tlast,
   input  logic [NUM_VFPGA-1:0]            s_axis_tvalid,
   output logic [NUM_VFPGA-1:0]            s_axis_tready,
   output logic [DATA_WIDTH-1:0]           m_axis_tdata,
   output logic [KW-1:0]                   m_axis_tkeep,
   output logic                            m_axis_tlast,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic [ROUTE_W-1:0]              route_out,
   output logic [PW-1:0]                   grant_id,
   output logic                            busy,
   output logic [31:0]                     pkt_cnt
);

   arb_state_t     state_q, state_d;
   route_t         route_q, route_d;
   logic [PW-1:0]  grant_q, grant_d;
   logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [31:0]    pkt_cnt_q, pkt_cnt_d;

   logic [NUM_VFPGA-1:0] req;
   logic [PW-1:0]        win;
   logic                 win_vld;

   assign req = s_axis_tvalid & ctrl_en_mask;

   rr_arbiter #(
      .NUM_VFPGA (NUM_VFPGA)
   ) u_rr (
      .req    (req),
      .rr_ptr (rr_ptr_q),
      .winner (win),
      .valid  (win_vld)
   );

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q   <= ST_IDLE;
         route_q   <= '0;
         grant_q   <= '0;
         rr_ptr_q  <= '0;
         pkt_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         route_q   <= route_d;
         grant_q   <= grant_d;
         rr_ptr_q  <= rr_ptr_d;
         pkt_cnt_q <= pkt_cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      route_d       = route_q;
      grant_d       = grant_q;
      rr_ptr_d      = rr_ptr_q;
      pkt_cnt_d     = pkt_cnt_q;
      m_axis_tdata  = '0;
      m_axis_tkeep  = '0;
      m_axis_tlast  = 1'b0;
      m_axis_tvalid = 1'b0;
      s_axis_tready = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (win_vld) begin
               grant_d  = win;
               rr_ptr_d = win;
               route_d  = route_t'(s_route[int'(win)*ROUTE_W +: ROUTE_W]);
               state_d  = ST_STREAM;
            end
         end
         ST_STREAM: begin
            // Grant is only released on the tlast handshake.
            m_axis_tdata  = s_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
            m_axis_tkeep  = s_axis_tkeep[int'(grant_q)*KW +: KW];
            m_axis_tlast  = s_axis_tlast[grant_q];
            m_axis_tvalid = s_axis_tvalid[grant_q];
            s_axis_tready[grant_q] = m_axis_tready;
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
               pkt_cnt_d = pkt_cnt_q + 32'd1;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign route_out = route_q;
   assign grant_id  = grant_q;
   assign busy      = (state_q == ST_STREAM);
   assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_viu_tx_arbiter.sv
// Scoreboard bench for viu_tx_arbiter: per-port beat sources, expected
// beats queued at issue, a negedge monitor pops on every output handshake.
module tb_viu_tx_arbiter;
   import viu_pkg::*;

   localparam int N  = 4;
   localparam int DW = 512;
   localparam int KW = 64;
   localparam int RW = 14;

   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   logic [N-1:0]    ctrl_en_mask = '1;
   logic [N*RW-1:0] s_route;
   logic [N*DW-1:0] s_axis_tdata;
   logic [N*KW-1:0] s_axis_tkeep;
   logic [N-1:0]    s_axis_tlast;
   logic [N-1:0]    s_axis_tvalid;
   logic [N-1:0]    s_axis_tready;
   logic [DW-1:0]   m_axis_tdata;
   logic [KW-1:0]   m_axis_tkeep;
   logic            m_axis_tlast;
   logic            m_axis_tvalid;
   logic            m_axis_tready = 1'b1;
   logic [RW-1:0]   route_out;
   logic [1:0]      grant_id;
   logic            busy;
   logic [31:0]     pkt_cnt;

   always #5 aclk = ~aclk;

   viu_tx_arbiter #(.NUM_VFPGA(N), .DATA_WIDTH(DW)) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .ctrl_en_mask  (ctrl_en_mask),
      .s_route       (s_route),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .route_out     (route_out),
      .grant_id      (grant_id),
      .busy          (busy),
      .pkt_cnt       (pkt_cnt)
   );

   logic [RW-1:0] rt [N];
   logic [DW-1:0] td [N];
   logic [KW-1:0] tk [N];
   logic [N-1:0]  tl = '0;
   logic [N-1:0]  tv = '0;

   for (genvar gp = 0; gp < N; gp++) begin : g_pack
      assign s_axis_tdata[gp*DW +: DW] = td[gp];
      assign s_axis_tkeep[gp*KW +: KW] = tk[gp];
      assign s_route[gp*RW +: RW]      = rt[gp];
   end
   assign s_axis_tlast  = tl;
   assign s_axis_tvalid = tv;

   typedef struct {
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic          l;
      int            gap;
   } beat_t;

   typedef struct {
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic          l;
      logic [1:0]    g;
      logic [RW-1:0] r;
   } exp_t;

   int checks = 0;
   int failures = 0;
   exp_t  sbq[$];
   beat_t mem [N][16];
   int    head [N];
   int    tail [N];
   int    gapcnt [N];
   logic [N-1:0] hs = '0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] mkd(int v);
      return {16{32'(v)}};
   endfunction

   task automatic push_src(int p, logic [DW-1:0] d, logic [KW-1:0] k,
                           logic l, int gap);
      mem[p][tail[p]] = '{d, k, l, gap};
      tail[p]++;
   endtask

   task automatic push_exp(int p, logic [DW-1:0] d, logic [KW-1:0] k,
                           logic l);
      sbq.push_back('{d, k, l, 2'(p), rt[p]});
   endtask

   task automatic push_beat(int p, int v, logic l, int gap);
      logic [KW-1:0] k;
      k = l ? 64'h0000_0000_FFFF_FFFF : '1;
      push_src(p, mkd(v), k, l, gap);
      push_exp(p, mkd(v), k, l);
   endtask

   task automatic flush();
      for (int p = 0; p < N; p++) begin
         head[p] = 0;
         tail[p] = 0;
         gapcnt[p] = 0;
         tv[p] = 1'b0;
         hs[p] = 1'b0;
      end
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      flush();
      sbq.delete();
      repeat (2) @(posedge aclk);
      #1;
      aresetn = 1'b1;
      ctrl_en_mask = '1;
      m_axis_tready = 1'b1;
   endtask

   task automatic chk_reset(string nm);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_grant"}, grant_id, 0);
      chk({nm, "_route"}, route_out, 0);
      chk({nm, "_pktcnt"}, pkt_cnt, 0);
      chk({nm, "_mvalid"}, m_axis_tvalid, 0);
      chk({nm, "_mlast"}, m_axis_tlast, 0);
      chk({nm, "_mdata0"}, m_axis_tdata == '0, 1);
      chk({nm, "_mkeep"}, m_axis_tkeep, 0);
      chk({nm, "_sready"}, s_axis_tready, 0);
   endtask

   task automatic wait_idle(string nm, int budget);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge aclk);
         #1;
         if (sbq.size() == 0 && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      chk({nm, "_drain"}, ok, 1);
   endtask

   // Per-port sources: pop on the handshake seen at the prior negedge.
   initial begin
      for (int p = 0; p < N; p++) begin
         td[p] = '0;
         tk[p] = '0;
      end
      flush();
      forever begin
         @(negedge aclk);
         for (int p = 0; p < N; p++) hs[p] = tv[p] & s_axis_tready[p];
         @(posedge aclk);
         #1;
         for (int p = 0; p < N; p++) begin
            if (hs[p] && head[p] < tail[p]) begin
               head[p]++;
               if (head[p] < tail[p]) gapcnt[p] = mem[p][head[p]].gap;
            end
            hs[p] = 1'b0;
            if (gapcnt[p] > 0) begin
               tv[p] = 1'b0;
               gapcnt[p]--;
            end else if (head[p] < tail[p]) begin
               tv[p] = 1'b1;
               td[p] = mem[p][head[p]].d;
               tk[p] = mem[p][head[p]].k;
               tl[p] = mem[p][head[p]].l;
            end else begin
               tv[p] = 1'b0;
               tl[p] = 1'b0;
            end
         end
      end
   end

   // Monitor: every accepted output beat must match the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(negedge aclk);
         if (aresetn && m_axis_tvalid && m_axis_tready) begin
            checks++;
            if (sbq.size() == 0) begin
               failures++;
               $display("FAIL beat_unexpected got g=%0d d=%h", grant_id,
                        m_axis_tdata[63:0]);
            end else begin
               e = sbq.pop_front();
               if (m_axis_tdata !== e.d || m_axis_tkeep !== e.k ||
                   m_axis_tlast !== e.l || grant_id !== e.g ||
                   route_out !== e.r) begin
                  failures++;
                  $display("FAIL beat got d=%h k=%h l=%b g=%0d r=%h exp d=%h k=%h l=%b g=%0d r=%h",
                           m_axis_tdata[63:0], m_axis_tkeep, m_axis_tlast,
                           grant_id, route_out, e.d[63:0], e.k, e.l, e.g, e.r);
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int hc [8];
      int n;
      int gaps;
      logic p1;
      logic ok;
      logic [3:0] pat;

      rt[0] = 14'h0ABC;
      rt[1] = 14'h0155;
      rt[2] = 14'h1234;
      rt[3] = 14'h2F0F;

      do_reset();
      chk_reset("rst");

      // Single 3-beat packet from port 2.
      for (int i = 0; i < 3; i++) push_beat(2, 'h200 + i, i == 2, 0);
      wait_idle("t1", 20);
      chk("t1_pktcnt", pkt_cnt, 1);
      chk("t1_grant", grant_id, 2);
      chk("t1_route_hold", route_out, 14'h1234);

      // All ports valid with 1-beat packets: order 1,2,3,0,1,2,3,0.
      do_reset();
      for (int i = 0; i < 8; i++) push_beat((i + 1) % 4, 'h300 + i, 1'b1, 0);
      n = 0;
      for (int c = 0; c < 80 && n < 8; c++) begin
         @(negedge aclk);
         if (m_axis_tvalid && m_axis_tready) begin
            hc[n] = c;
            n++;
         end
      end
      chk("t2_hs_count", n, 8);
      for (int i = 1; i < n; i++) chk("t2_spacing", hc[i] - hc[i-1], 2);
      wait_idle("t2", 20);
      chk("t2_pktcnt", pkt_cnt, 8);

      // Backpressure on port 0 while port 1 waits.
      do_reset();
      for (int i = 0; i < 4; i++) push_beat(0, 'h400 + i, i == 3, 0);
      pat = 4'b1001;
      p1 = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 80; c++) begin
         @(posedge aclk);
         #1;
         m_axis_tready = pat[c % 4];
         if (!p1 && busy && grant_id == 2'd0) begin
            push_beat(1, 'h480, 1'b1, 0);
            p1 = 1'b1;
         end
         if (p1 && sbq.size() == 0 && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      m_axis_tready = 1'b1;
      chk("t3_done", ok, 1);
      chk("t3_pktcnt", pkt_cnt, 2);

      // Enable mask: only port 3 eligible, then masked mid-packet.
      do_reset();
      ctrl_en_mask = 4'b1011;
      for (int i = 0; i < 3; i++) push_beat(3, 'h500 + i, i == 2, 0);
      push_src(2, mkd('h520), 64'h0000_0000_FFFF_FFFF, 1'b1, 0);
      push_src(3, mkd('h530), '1, 1'b0, 0);
      push_src(3, mkd('h531), 64'h0000_0000_FFFF_FFFF, 1'b1, 0);
      ok = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(posedge aclk);
         #1;
         if (busy && grant_id == 2'd3) begin
            ok = 1'b1;
            break;
         end
      end
      chk("t4_grant3", ok, 1);
      ctrl_en_mask = 4'b0011;
      wait_idle("t4a", 20);
      repeat (10) @(posedge aclk);
      #1;
      chk("t4_wait_busy", busy, 0);
      chk("t4_wait_mvalid", m_axis_tvalid, 0);
      chk("t4_wait_pktcnt", pkt_cnt, 1);
      push_exp(2, mkd('h520), 64'h0000_0000_FFFF_FFFF, 1'b1);
      push_exp(3, mkd('h530), '1, 1'b0);
      push_exp(3, mkd('h531), 64'h0000_0000_FFFF_FFFF, 1'b1);
      ctrl_en_mask = 4'b1111;
      wait_idle("t4b", 30);
      chk("t4_pktcnt", pkt_cnt, 3);

      // Granted port 1 drops tvalid for 5 cycles before beat 2.
      do_reset();
      for (int i = 0; i < 4; i++) push_beat(1, 'h600 + i, i == 3, i == 2 ? 5 : 0);
      gaps = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge aclk);
         if (busy && !tv[1]) begin
            gaps++;
            chk("t5_gap_mvalid", m_axis_tvalid, 0);
            chk("t5_gap_grant", grant_id, 1);
            chk("t5_gap_route", route_out, rt[1]);
         end
         if (sbq.size() == 0 && !busy) break;
      end
      chk("t5_gap_cycles", gaps, 5);
      wait_idle("t5", 10);
      chk("t5_pktcnt", pkt_cnt, 1);

      // Reset pulsed while port 2's beat 2 is on the bus.
      for (int i = 0; i < 4; i++) begin
         push_src(2, mkd('h700 + i), '1, i == 3, 0);
         if (i < 2) push_exp(2, mkd('h700 + i), '1, 1'b0);
      end
      ok = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(posedge aclk);
         #1;
         if (sbq.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      chk("t6_two_beats", ok, 1);
      chk("t6_busy_pre", busy, 1);
      aresetn = 1'b0;
      @(posedge aclk);
      #1;
      flush();
      aresetn = 1'b1;
      chk_reset("t6_rst");
      push_beat(3, 'h780, 1'b1, 0);
      wait_idle("t6", 20);
      chk("t6_pktcnt", pkt_cnt, 1);
      chk("t6_grant", grant_id, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/viu_tx_arbiter.md
Name: viu_tx_arbiter

Overview:
- Per-packet round-robin arbiter in the VIU TX path. It shares one VLAN-tagger ingress between NUM_VFPGA vFPGA transmit streams.
- Grants one whole packet at a time and forwards that requester's AXI-Stream beats unmodified.
- Holds the 14-bit route control word (route_out) stable from grant until the granted packet's last beat is accepted. This guarantees the tagger sees a consistent route for the full frame.

Parameters:
- NUM_VFPGA, 4, number of requesting vFPGA streams (2..16).
- DATA_WIDTH, AXI_NET_BITS (512), AXI-Stream data width in bits.

Ports:
- aclk  input  1  clock.
- aresetn  input  1  synchronous active-low reset.
- ctrl_en_mask  input  NUM_VFPGA  per-requester enable; sampled only at arbitration.
- s_route  input  NUM_VFPGA*14  per-requester route word, format {src_node[13:12], src_vfpga[11:8], dst_node[7:6], dst_vfpga[5:2], rsvd[1:0]}.
- s_axis_tdata  input  NUM_VFPGA*DATA_WIDTH  requester data.
- s_axis_tkeep  input  NUM_VFPGA*DATA_WIDTH/8  requester keep.
- s_axis_tlast  input  NUM_VFPGA  requester last.
- s_axis_tvalid  input  NUM_VFPGA  requester valid.
- s_axis_tready  output  NUM_VFPGA  requester ready.
- m_axis_tdata  output  DATA_WIDTH  to tagger.
- m_axis_tkeep  output  DATA_WIDTH/8  to tagger.
- m_axis_tlast  output  1  to tagger.
- m_axis_tvalid  output  1  to tagger.
- m_axis_tready  input  1  from tagger.
- route_out  output  14  route word for tagger; registered.
- grant_id  output  clog2(NUM_VFPGA)  index of current or last granted requester; registered.
- busy  output  1  high while in ST_STREAM.
- pkt_cnt  output  32  packets completed (tlast handshakes); wraps at 2^32-1 -> 0.

Behaviour:
- Reset values:
  - state = ST_IDLE; route_out = 0; grant_id = 0; rr_ptr = 0; pkt_cnt = 0.
  - All s_axis_tready = 0; m_axis_tvalid = 0; m_axis_tlast = 0; m_axis_tdata = 0; m_axis_tkeep = 0.
- Request vector: req[i] = s_axis_tvalid[i] & ctrl_en_mask[i].
- ST_IDLE:
  - Outputs m_axis_tvalid = 0 and s_axis_tready = 0.
  - If req != 0, pick the first set req at or after index (rr_ptr+1) mod NUM_VFPGA, scanning upward with wrap.
  - Register grant_id = winner, route_out = s_route[winner], and rr_ptr = winner, then go to ST_STREAM.
  - If req == 0, stay in ST_IDLE.
- ST_STREAM (combinational pass-through of the granted port g = grant_id):
  - m_axis_tdata/tkeep/tlast/tvalid = port g's signals.
  - s_axis_tready[g] = m_axis_tready; all other s_axis_tready = 0.
  - On m_axis_tvalid & m_axis_tready & m_axis_tlast: pkt_cnt += 1, go to ST_IDLE.
- Latency:
  - Zero-cycle data path in ST_STREAM.
  - One arbitration bubble cycle (ST_IDLE) between consecutive packets.
  - First beat of a granted packet is presented on the cycle after the request is seen.
- route_out and grant_id change only on the ST_IDLE -> ST_STREAM transition. They hold their last values while in ST_IDLE.
- Boundary conditions:
  - Backpressure (m_axis_tready = 0): stay in ST_STREAM, hold the grant; no beat is lost or duplicated.
  - Granted requester drops tvalid mid-packet: keep the grant and wait. No timeout; other requesters are never interleaved within a packet.
  - ctrl_en_mask bit cleared mid-packet: the in-flight packet completes; the mask takes effect at the next arbitration.
  - Single-beat packet (tlast on first beat): ST_STREAM lasts one handshake cycle, then ST_IDLE.
  - Only one requester active: it wins every arbitration, giving back-to-back packets with one bubble each.
  - All NUM_VFPGA requesting: grants rotate strictly in order rr_ptr+1, rr_ptr+2, … with wrap.
  - Reset asserted mid-packet: immediate return to reset values on the next clock edge. The partial frame is truncated; downstream must also be reset.
- Width rules:
  - grant_id and rr_ptr have width max(1, clog2(NUM_VFPGA)).
  - The modulo wrap uses an explicit compare against NUM_VFPGA-1, not power-of-two truncation.

Decomposition:
- Shared package (viu_pkg):
  - ROUTE_W = 14.
  - route_t packed struct {src_node[1:0], src_vfpga[3:0], dst_node[1:0], dst_vfpga[3:0], rsvd[1:0]}, also used by vlan_tagger and gateway_tx.
  - arb_state_t enum {ST_IDLE, ST_STREAM}.
- Sub-module: rr_arbiter, a combinational round-robin picker with inputs req and rr_ptr and outputs winner index and valid. Pure logic, parameterised by NUM_VFPGA, reusable on the RX side.

Test Plan:
- Reset, then requester 2 sends a 3-beat packet with s_route = 14'h1234 -> grant_id = 2 and route_out = 14'h1234 from the first beat to the last; beats identical at output; pkt_cnt = 1.
- NUM_VFPGA = 4, all ports continuously valid with 1-beat packets, rr_ptr = 0 after reset -> grant order 1, 2, 3, 0, 1…; one idle cycle between beats; pkt_cnt = 8 after 8 packets.
- Port 0 mid 4-beat packet with m_axis_tready toggling 1,0,0,1 and port 1 requesting -> port 1 never granted until port 0's tlast handshake; no beat dropped or duplicated.
- ctrl_en_mask = 4'b1011, ports 2 and 3 valid -> only port 3 granted; clearing bit 3 mid-packet lets that packet finish; next grant then waits for an enabled requester.
- Granted port deasserts tvalid for 5 cycles mid-packet -> m_axis_tvalid = 0 during the gap; grant_id and route_out unchanged; stream resumes on the same port.
- aresetn pulsed low during beat 2 of a packet -> next cycle all outputs at reset values, state ST_IDLE, pkt_cnt = 0; a new request is then granted normally.
